// File: rtl/fsm_seq_pkg.sv
// Shared state encoding, drive codes and response codes for the protocol-unit sequencer.
package fsm_seq_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned CODE_W  = 2;
    localparam int unsigned RSP_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 4'd0,
        ST_STEP_S1  = 4'd1,
        ST_CHK_S1   = 4'd2,
        ST_STEP_S2  = 4'd3,
        ST_CHK_S2   = 4'd4,
        ST_STEP_RET = 4'd5,
        ST_CHK_RET  = 4'd6,
        ST_RECOVER  = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

    // Drive codes {i1,i2} presented to the protocol unit
    localparam logic [CODE_W-1:0] STEP_FWD = 2'b11;
    localparam logic [CODE_W-1:0] STEP_RET = 2'b10;
    localparam logic [CODE_W-1:0] HOLD_S2  = 2'b01;
    localparam logic [CODE_W-1:0] HOLD     = 2'b00;

    // Response codes {o1,o2,err} returned by the protocol unit
    localparam logic [RSP_W-1:0] RSP_S1   = 3'b100;
    localparam logic [RSP_W-1:0] RSP_S2   = 3'b010;
    localparam logic [RSP_W-1:0] RSP_IDLE = 3'b000;
    localparam logic [RSP_W-1:0] RSP_ERR  = 3'b111;

    // Code driven while the sequencer sits in a given state
    function automatic logic [CODE_W-1:0] drive_code(input state_t s);
        case (s)
            ST_STEP_S1,
            ST_STEP_S2:  drive_code = STEP_FWD;
            ST_STEP_RET: drive_code = STEP_RET;
            ST_CHK_S2:   drive_code = HOLD_S2;
            default:     drive_code = HOLD;
        endcase
    endfunction

endpackage

// File: rtl/fsm_seq_ctrl_timer.sv
// Per-state wait timer: expired is high on the TIMEOUT-th cycle since the last clear.
module seq_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Count cycles in the current state, saturating at the expiry point
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (enable && (cnt != LAST)) begin
            cnt     <= CNT_W'(cnt + CNT_W'(1));
            expired <= (CNT_W'(cnt + CNT_W'(1)) == LAST);
        end
    end

endmodule

// File: rtl/fsm_seq_ctrl.sv
// Sequencer driving the protocol unit through IDLE->S1->S2->IDLE passes with check, recovery and retry.
module fsm_seq_ctrl
    import fsm_seq_pkg::*;
#(
    parameter int unsigned PASS_W    = 8,
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [PASS_W-1:0] passes,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [PASS_W-1:0] pass_cnt,
    output logic [1:0]        retry_cnt,
    output logic [3:0]        err_cnt,
    output logic              p_i1,
    output logic              p_i2,
    input  logic              p_o1,
    input  logic              p_o2,
    input  logic              p_err
);

    state_t            state, state_nx;
    logic [PASS_W-1:0] passes_q, passes_nx;
    logic [PASS_W-1:0] pass_nx;
    logic [1:0]        retry_nx;
    logic [3:0]        err_nx;
    logic              fail_nx;
    logic [RSP_W-1:0]  rsp;
    logic              err_seen;
    logic              expired;
    logic              tmr_clear;

    assign rsp       = {p_o1, p_o2, p_err};
    // Full error signature or a bare err flag both count as an error observation
    assign err_seen  = p_err || (rsp == RSP_ERR);
    assign tmr_clear = (state_nx != state);

    seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (tmr_clear),
        .enable  (1'b1),
        .expired (expired)
    );

    // State, latched pass request and all outputs; outputs decoded from next state
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            passes_q  <= '0;
            pass_cnt  <= '0;
            retry_cnt <= '0;
            err_cnt   <= '0;
            fail      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            p_i1      <= 1'b0;
            p_i2      <= 1'b0;
        end else begin
            state        <= state_nx;
            passes_q     <= passes_nx;
            pass_cnt     <= pass_nx;
            retry_cnt    <= retry_nx;
            err_cnt      <= err_nx;
            fail         <= fail_nx;
            busy         <= (state_nx != ST_IDLE) && (state_nx != ST_DONE);
            done         <= (state_nx == ST_DONE);
            {p_i1, p_i2} <= drive_code(state_nx);
        end
    end

    // Next-state, counter and status decode
    always_comb begin
        state_nx  = state;
        passes_nx = passes_q;
        pass_nx   = pass_cnt;
        retry_nx  = retry_cnt;
        err_nx    = err_cnt;
        fail_nx   = fail;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    passes_nx = passes;
                    pass_nx   = '0;
                    retry_nx  = '0;
                    err_nx    = '0;
                    fail_nx   = 1'b0;
                    state_nx  = (passes == '0) ? ST_DONE : ST_STEP_S1;
                end
            end
            ST_STEP_S1:  state_nx = ST_CHK_S1;
            ST_STEP_S2:  state_nx = ST_CHK_S2;
            ST_STEP_RET: state_nx = ST_CHK_RET;
            ST_CHK_S1, ST_CHK_S2, ST_CHK_RET: begin
                if ((state == ST_CHK_S1 && rsp == RSP_S1) ||
                    (state == ST_CHK_S2 && rsp == RSP_S2) ||
                    (state == ST_CHK_RET && rsp == RSP_IDLE)) begin
                    if (state == ST_CHK_S1) begin
                        state_nx = ST_STEP_S2;
                    end else if (state == ST_CHK_S2) begin
                        state_nx = ST_STEP_RET;
                    end else begin
                        pass_nx  = PASS_W'(pass_cnt + PASS_W'(1));
                        state_nx = (pass_nx == passes_q) ? ST_DONE : ST_STEP_S1;
                    end
                end else if (err_seen) begin
                    err_nx   = (err_cnt == 4'hF) ? err_cnt : 4'(err_cnt + 4'd1);
                    state_nx = ST_RECOVER;
                end else if (expired) begin
                    fail_nx  = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_RECOVER: begin
                if (rsp == RSP_IDLE) begin
                    if (32'(retry_cnt) < MAX_RETRY) begin
                        retry_nx = (retry_cnt == 2'd3) ? retry_cnt : 2'(retry_cnt + 2'd1);
                        state_nx = ST_STEP_S1;
                    end else begin
                        fail_nx  = 1'b1;
                        state_nx = ST_DONE;
                    end
                end else if (expired) begin
                    fail_nx  = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed bench for fsm_seq_ctrl with a behavioural protocol-unit model.
module tb_fsm_seq_ctrl;
    import fsm_seq_pkg::*;

    logic       clk;
    logic       nrst;
    logic       start;
    logic [7:0] passes;
    logic       busy, done, fail;
    logic [7:0] pass_cnt;
    logic [1:0] retry_cnt;
    logic [3:0] err_cnt;
    logic       p_i1, p_i2, p_o1, p_o2, p_err;

    int errors = 0;
    int checks = 0;

    logic [1:0]  hist [0:63];
    logic [18:0] outv;
    assign outv = {busy, done, fail, pass_cnt, retry_cnt, err_cnt, p_i1, p_i2};

    fsm_seq_ctrl #(.PASS_W(8), .MAX_RETRY(2), .TIMEOUT(15)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .passes    (passes),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .pass_cnt  (pass_cnt),
        .retry_cnt (retry_cnt),
        .err_cnt   (err_cnt),
        .p_i1      (p_i1),
        .p_i2      (p_i2),
        .p_o1      (p_o1),
        .p_o2      (p_o2),
        .p_err     (p_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural protocol unit: registered state, optional injected errors and freeze
    typedef enum logic [1:0] {U_IDLE, U_S1, U_S2, U_ERR} ust_t;
    ust_t        ust;
    logic        u_nrst;
    logic        freeze;
    int unsigned err_budget;
    int unsigned err_used;
    logic [2:0]  rsp_m;

    always_ff @(posedge clk or negedge u_nrst) begin
        if (!u_nrst) begin
            ust      <= U_IDLE;
            err_used <= 0;
        end else if (!freeze) begin
            case (ust)
                U_IDLE: if ({p_i1, p_i2} == STEP_FWD) ust <= U_S1;
                        else if ({p_i1, p_i2} != HOLD) ust <= U_ERR;
                U_S1: begin
                    if ({p_i1, p_i2} == STEP_FWD) begin
                        if (err_used < err_budget) begin
                            ust      <= U_ERR;
                            err_used <= err_used + 1;
                        end else begin
                            ust <= U_S2;
                        end
                    end else if ({p_i1, p_i2} != HOLD) begin
                        ust <= U_ERR;
                    end
                end
                U_S2: if ({p_i1, p_i2} == STEP_RET) ust <= U_IDLE;
                      else if ({p_i1, p_i2} == STEP_FWD) ust <= U_ERR;
                default: if ({p_i1, p_i2} == HOLD) ust <= U_IDLE;
            endcase
        end
    end

    always_comb begin
        rsp_m = RSP_IDLE;
        case (ust)
            U_S1:    rsp_m = RSP_S1;
            U_S2:    rsp_m = RSP_S2;
            U_ERR:   rsp_m = RSP_ERR;
            default: rsp_m = RSP_IDLE;
        endcase
    end
    assign {p_o1, p_o2, p_err} = rsp_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command after an idle cycle; lat counts edges from acceptance to done
    task automatic run_cmd(input logic [7:0] n, input int spur_at, output int lat);
        @(posedge clk); #1;
        start  = 1'b1;
        passes = n;
        @(posedge clk); #1;
        start  = 1'b0;
        passes = 8'hA5;
        lat    = 0;
        hist[0] = {p_i1, p_i2};
        while (!done && lat < 400) begin
            if (lat == spur_at) begin
                start  = 1'b1;
                passes = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (lat < 64) hist[lat] = {p_i1, p_i2};
        end
        start = 1'b0;
        if (!done) chk("done_wait", 32'(done), 32'd1);
    endtask

    task automatic unit_reset();
        u_nrst = 1'b0;
        #1;
        u_nrst = 1'b1;
    endtask

    logic [1:0]  pat [0:5];
    logic [25:0] got_v, exp_v;
    int          lat;
    logic        seen_done;

    initial begin
        pat = '{2'b11, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00};
        nrst = 1'b0; u_nrst = 1'b0; start = 1'b0; passes = '0;
        freeze = 1'b0; err_budget = 0;
        #1;
        chk("reset_outs", 32'(outv), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1; u_nrst = 1'b1;
        @(posedge clk); #1;
        chk("idle_outs", 32'(outv), 32'd0);

        // Two healthy passes
        run_cmd(8'd2, -1, lat);
        chk("p2_lat", 32'(lat), 32'd12);
        chk("p2_pass_cnt", 32'(pass_cnt), 32'd2);
        chk("p2_fail", 32'(fail), 32'd0);
        chk("p2_retry", 32'(retry_cnt), 32'd0);
        chk("p2_err", 32'(err_cnt), 32'd0);
        chk("p2_busy_at_done", 32'(busy), 32'd0);
        for (int k = 0; k < 13; k++) begin
            got_v[2*k +: 2] = hist[k];
            exp_v[2*k +: 2] = (k < 12) ? pat[k % 6] : 2'b00;
        end
        chk("p2_drive_seq", 32'(got_v), 32'(exp_v));
        @(posedge clk); #1;
        chk("p2_done_pulse", 32'(done), 32'd0);

        // Zero passes
        run_cmd(8'd0, -1, lat);
        chk("p0_lat", 32'(lat), 32'd0);
        chk("p0_pass_cnt", 32'(pass_cnt), 32'd0);
        chk("p0_drive", 32'(hist[0]), 32'd0);
        @(posedge clk); #1;
        chk("p0_after", 32'({done, busy, p_i1, p_i2}), 32'd0);

        // One injected error in the first S2 step, recovered by a retry
        unit_reset();
        err_budget = 1;
        run_cmd(8'd1, -1, lat);
        chk("e1_lat", 32'(lat), 32'd12);
        chk("e1_retry", 32'(retry_cnt), 32'd1);
        chk("e1_err", 32'(err_cnt), 32'd1);
        chk("e1_fail", 32'(fail), 32'd0);
        chk("e1_pass_cnt", 32'(pass_cnt), 32'd1);

        // Error on every attempt exhausts the retry limit
        unit_reset();
        err_budget = 100;
        run_cmd(8'd1, -1, lat);
        chk("eall_lat", 32'(lat), 32'd18);
        chk("eall_err", 32'(err_cnt), 32'd3);
        chk("eall_retry", 32'(retry_cnt), 32'd2);
        chk("eall_fail", 32'(fail), 32'd1);
        chk("eall_pass_cnt", 32'(pass_cnt), 32'd0);
        unit_reset();
        err_budget = 0;

        // Unit frozen at idle: timeout in CHK_S1, spurious start while busy
        freeze = 1'b1;
        run_cmd(8'd2, 4, lat);
        chk("to_lat", 32'(lat), 32'd16);
        chk("to_fail", 32'(fail), 32'd1);
        chk("to_pass_cnt", 32'(pass_cnt), 32'd0);
        chk("to_err", 32'(err_cnt), 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            seen_done = seen_done | busy | done;
        end
        chk("to_no_restart", 32'(seen_done), 32'd0);
        chk("to_fail_held", 32'(fail), 32'd1);
        freeze = 1'b0;

        // Asynchronous reset in the middle of CHK_S2
        @(posedge clk); #1;
        start = 1'b1; passes = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("rst_pre_drive", 32'({busy, p_i1, p_i2}), 32'b101);
        #2;
        nrst = 1'b0; u_nrst = 1'b0;
        #1;
        chk("rst_outs", 32'(outv), 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            seen_done = seen_done | done;
        end
        chk("rst_no_done", 32'(seen_done), 32'd0);
        @(negedge clk);
        nrst = 1'b1; u_nrst = 1'b1;
        run_cmd(8'd1, -1, lat);
        chk("rst_run_lat", 32'(lat), 32'd6);
        chk("rst_run_pass", 32'(pass_cnt), 32'd1);
        chk("rst_run_fail", 32'(fail), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsm_seq_ctrl.md
# fsm_seq_ctrl

Sequencer that drives the team's three-state protocol unit (inputs i1/i2, outputs o1/o2/err) through complete IDLE→S1→S2→IDLE passes on command. It issues the step and hold codes, checks each registered response, recovers the unit from ERROR, retries failed passes up to a limit, and reports completion, pass count and failure status. It sits between a host command interface and one protocol-unit instance.

## Interface
- PASS_W, 8, width of pass-count request and counter
- MAX_RETRY, 2, failed passes tolerated per command before fail
- TIMEOUT, 15, max cycles waiting for an expected response (≥2)
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- start  in  1  command pulse; sampled only when busy=0
- passes  in  PASS_W  passes to run; sampled with start
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- fail  out  1  last command failed; held until next accepted start
- pass_cnt  out  PASS_W  passes completed in current/last command
- retry_cnt  out  2  retries used, saturating at 3
- err_cnt  out  4  err observations, saturating at 15
- p_i1, p_i2  out  1  drive to protocol unit i1/i2, registered
- p_o1, p_o2, p_err  in  1  response from protocol unit (registered there)

## Operation
- States: IDLE, STEP_S1, CHK_S1, STEP_S2, CHK_S2, STEP_RET, CHK_RET, RECOVER, DONE.
- Drive codes {p_i1,p_i2}: STEP_S1 11, STEP_S2 11, STEP_RET 10; all CHK_S1/RECOVER/IDLE/DONE 00; CHK_S2 01 (holds S2); CHK_RET 00.
- Expected {p_o1,p_o2,p_err}: CHK_S1 100, CHK_S2 010, CHK_RET 000.
- IDLE: start with busy=0 → clear pass_cnt, retry_cnt, err_cnt, fail; passes=0 → DONE, else STEP_S1.
- STEP_x: exactly one cycle, then CHK_x.
- CHK_x: response == expected → next STEP (CHK_RET: pass_cnt+1; equals passes → DONE, else STEP_S1). p_err=1 → err_cnt+1, RECOVER. Otherwise wait; TIMEOUT cycles in state → fail=1, DONE.
- RECOVER: drive 00; on response 000 → if retry_cnt < MAX_RETRY, retry_cnt+1, STEP_S1 (failed pass not counted); else fail=1, DONE. Timeout applies identically.
- DONE: one cycle, done=1, busy=0, → IDLE.
- start while busy: ignored. passes changes after acceptance: ignored (latched copy).
- Reset values: all outputs 0, p_i1=p_i2=0, state IDLE.

## Timing
- p_i1/p_i2 registered from next-state decode: step code is present for exactly one rising edge of the protocol unit.
- Healthy unit: each CHK matches in its first cycle; one pass = 6 cycles.
- start sampled at edge E0: busy=1 from E0 to E0+6N; done=1 during cycle [E0+6N, E0+6N+1); passes=0 → done in cycle after E0.
- Timeout counter resets on every state entry; fires on the TIMEOUT-th consecutive cycle without match.
- nrst assertion mid-command: immediate return to reset values; no done pulse; protocol unit reset separately.

## Structure
- Package fsm_seq_pkg: state encoding localparams, drive codes (STEP_FWD=2'b11, STEP_RET=2'b10, HOLD_S2=2'b01, HOLD=2'b00), expected response codes (RSP_S1=3'b100, RSP_S2=3'b010, RSP_IDLE=3'b000, RSP_ERR=3'b111).
- One sub-module: seq_timer (clear, enable, expired at TIMEOUT).
- Saturating counters inline.

## Test plan
- passes=2, behavioural unit model → done 12 cycles after start edge, pass_cnt=2, fail=0, retry_cnt=0, drive sequence 11,00,11,01,10,00 twice.
- passes=0 → done in next cycle, pass_cnt=0, p_i1/p_i2 stay 00.
- Model forces err in first CHK_S2 → RECOVER, return to 000, retry_cnt=1, err_cnt=1, passes=1 completes with fail=0, pass_cnt=1.
- Model forces err on every pass, MAX_RETRY=2 → err_cnt=3, retry_cnt=2, fail=1, pass_cnt=0, done pulse.
- Model frozen at 000 in CHK_S1 → fail=1 and done after 15 cycles in CHK_S1; start during busy ignored.
- nrst low mid CHK_S2 → all outputs 0 immediately, no done; new start after release runs normally.
